multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle sequencer for the LEGv8 datapath. Replaces per-instruction combinational decode with an FSM.
//  Steps FETCH/DECODE/EXEC/MEM/WB, holds memory strobes until the memory handshake completes.
//  Drives the IR, PC, regfile, ALU and data memory enables. Counts retired instructions.
// PARAMETERS
//  MEM_TO   default 16  max cycles waiting on imem_ready/dmem_ready before abort (>=2)
//  CNT_W    default 32  width of retired-instruction counter
// PORTS
//  CLK            in   1      system clock, rising edge
//  resetl         in   1      asynchronous active-low reset
//  opcode         in   11     instr[31:21] from IR; valid from DECODE onward
//  zero           in   1      ALU zero flag, sampled in EXEC
//  imem_ready     in   1      instruction memory data valid
//  dmem_ready     in   1      data memory access complete
//  ir_write       out  1      load IR this cycle
//  pc_write       out  1      update PC this cycle
//  pcsrc          out  1      1: PC<=branch target, 0: PC<=PC+4
//  reg2loc,alusrc,mem2reg,regwrite,memread,memwrite  out 1 each  datapath controls
//  aluop          out  4      0000 AND,0001 ORR,0010 ADD,0110 SUB,0111 pass-B
//  signop         out  3      000 I,001 D,010 B,011 CB,100 IW (MOVZ)
//  state          out  3      FETCH=0,DECODE=1,EXEC=2,MEM=3,WB=4
//  illegal        out  1      sticky: undecodable opcode seen
//  timeout        out  1      sticky: memory wait exceeded MEM_TO
//  retired        out  CNT_W  instructions completed, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (resetl=0, async): state=FETCH, all strobes 0, aluop=0, signop=0, illegal=timeout=0, retired=0.
//  - Opcode classes (casez, first match wins):
//    ANDREG ?0001010???, ORRREG ?0101010???, ADDREG ?0?01011???, SUBREG ?1?01011???,
//    ADDIMM ?0?10001???, SUBIMM ?1?10001???, B ?00101?????, CBZ ?011010????,
//    LDUR ??111000010, STUR ??111000000.
//  - Per-class datapath values:
//    R-type: reg2loc=0, alusrc=0.
//    Imm: alusrc=1, signop=000.
//    LDUR/STUR: alusrc=1, aluop=0010, signop=001.
//    STUR/CBZ: reg2loc=1.
//    CBZ: aluop=0111, signop=011. B: signop=010.
//  - Datapath control outputs are driven from opcode in DECODE..WB; all 0 in FETCH.
//  - FETCH: ir_write=1 on the cycle imem_ready=1, then ->DECODE. No ready -> stay, wait counter increments.
//  - DECODE: 1 cycle. Illegal opcode -> set illegal, pc_write=1, pcsrc=0, ->FETCH (skip instr, not retired).
//  - EXEC: 1 cycle.
//    B: pc_write=1, pcsrc=1, retire, ->FETCH.
//    CBZ: pc_write=1, pcsrc=zero, retire, ->FETCH.
//    LDUR/STUR: ->MEM. Others: ->WB.
//  - MEM: memread (LDUR) or memwrite (STUR) held high until the cycle dmem_ready=1.
//    LDUR ->WB. STUR: pc_write=1, pcsrc=0, retire, ->FETCH.
//  - WB: regwrite=1 for exactly 1 cycle (mem2reg=1 only for LDUR); pc_write=1, pcsrc=0, retire, ->FETCH.
//  - Latency: ALU ops 4 cycles; STUR 4+; LDUR 5+; B/CBZ 3, each plus memory wait cycles.
//  - Wait counter: clears on every state change. If it reaches MEM_TO-1 in FETCH/MEM without ready:
//    set timeout, drop strobes, pc_write=1, pcsrc=0, ->FETCH; instruction not retired.
//  - ready asserted while not waiting is ignored.
//  - retired increments on the same edge as the completing pc_write; 2^CNT_W-1 wraps to 0.
//  - Sticky flags cleared only by reset. Reset mid-MEM drops memread/memwrite immediately (async).
// CONFIGURATION
//  MOVZ_EN defined:
//    MOVZ 110100101?? decodes (checked before B/CBZ): alusrc=1, aluop=0111, signop=100, EXEC->WB, regwrite.
//  MOVZ_EN undefined:
//    MOVZ is illegal (illegal=1, skipped). Signop code 100 is never driven.
// TESTING
//  1) reset; ADDREG 0x458, imem_ready=1 -> states 0,1,2,4; regwrite 1 cycle in WB, aluop=0010; retired=1.
//  2) LDUR 0x7C2, dmem_ready after 3 MEM cycles -> memread high exactly 3 cycles, then WB mem2reg=1; retired+1.
//  3) CBZ 0x5A0, zero=1 -> EXEC pc_write=1, pcsrc=1; repeat zero=0 -> pcsrc=0; no regwrite either case.
//  4) STUR, dmem_ready held 0 -> after 16 MEM cycles: timeout=1, memwrite=0, state=FETCH, retired unchanged.
//  5) opcode 0x000 -> illegal=1, PC+4, retired unchanged; then resetl=0 mid-MEM -> all strobes 0 without CLK edge.
//  6) MOVZ 0x694: with MOVZ_EN -> signop=100, aluop=0111, regwrite; without MOVZ_EN -> illegal=1.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the LEGv8 datapath.
// Drives IR/PC/regfile/ALU/data-memory enables from the IR opcode and counts retired instructions.
// Optional feature: define MOVZ_EN to decode MOVZ; without it MOVZ is skipped as illegal.
//
// state  | meaning
// FETCH  | wait for imem_ready, load IR on the ready cycle
// DECODE | classify opcode; illegal opcodes are skipped (PC+4)
// EXEC   | ALU step; B/CBZ complete here
// MEM    | hold memread/memwrite until dmem_ready
// WB     | one-cycle register write-back, PC+4, retire
module multicycle_control #(
  parameter int MEM_TO = 16,
  parameter int CNT_W  = 32
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pcsrc,
  output logic             reg2loc,
  output logic             alusrc,
  output logic             mem2reg,
  output logic             regwrite,
  output logic             memread,
  output logic             memwrite,
  output logic [3:0]       aluop,
  output logic [2:0]       signop,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [3:0] CL_ILL  = 4'd0;
  localparam logic [3:0] CL_AND  = 4'd1;
  localparam logic [3:0] CL_ORR  = 4'd2;
  localparam logic [3:0] CL_ADD  = 4'd3;
  localparam logic [3:0] CL_SUB  = 4'd4;
  localparam logic [3:0] CL_ADDI = 4'd5;
  localparam logic [3:0] CL_SUBI = 4'd6;
`ifdef MOVZ_EN
  localparam logic [3:0] CL_MOVZ = 4'd7;
`endif
  localparam logic [3:0] CL_B    = 4'd8;
  localparam logic [3:0] CL_CBZ  = 4'd9;
  localparam logic [3:0] CL_LDUR = 4'd10;
  localparam logic [3:0] CL_STUR = 4'd11;

  localparam int              WAIT_W    = $clog2(MEM_TO);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TO - 1);

  logic [3:0]        cls;
  logic [2:0]        state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              retire;
  logic              set_ill;
  logic              set_to;
  logic              fetch_rdy;

  // ir_write is combinational from imem_ready, so it must also be held off while in reset
  assign fetch_rdy = imem_ready & resetl;

  // opcode classification, first matching pattern wins
  always_comb begin
    cls = CL_ILL;
    casez (opcode)
      11'b?0001010???: cls = CL_AND;
      11'b?0101010???: cls = CL_ORR;
      11'b?0?01011???: cls = CL_ADD;
      11'b?1?01011???: cls = CL_SUB;
      11'b?0?10001???: cls = CL_ADDI;
      11'b?1?10001???: cls = CL_SUBI;
`ifdef MOVZ_EN
      11'b110100101??: cls = CL_MOVZ;
`endif
      11'b?00101?????: cls = CL_B;
      11'b?011010????: cls = CL_CBZ;
      11'b??111000010: cls = CL_LDUR;
      11'b??111000000: cls = CL_STUR;
      default:         cls = CL_ILL;
    endcase
  end

  // datapath controls follow the opcode from DECODE through WB, forced low in FETCH
  always_comb begin
    reg2loc = 1'b0;
    alusrc  = 1'b0;
    mem2reg = 1'b0;
    aluop   = 4'b0000;
    signop  = 3'b000;
    if (state != S_FETCH) begin
      case (cls)
        CL_AND:  aluop = 4'b0000;
        CL_ORR:  aluop = 4'b0001;
        CL_ADD:  aluop = 4'b0010;
        CL_SUB:  aluop = 4'b0110;
        CL_ADDI: begin alusrc = 1'b1; aluop = 4'b0010; end
        CL_SUBI: begin alusrc = 1'b1; aluop = 4'b0110; end
`ifdef MOVZ_EN
        CL_MOVZ: begin alusrc = 1'b1; aluop = 4'b0111; signop = 3'b100; end
`endif
        CL_B:    signop = 3'b010;
        CL_CBZ:  begin reg2loc = 1'b1; aluop = 4'b0111; signop = 3'b011; end
        CL_LDUR: begin alusrc = 1'b1; aluop = 4'b0010; signop = 3'b001; mem2reg = 1'b1; end
        CL_STUR: begin reg2loc = 1'b1; alusrc = 1'b1; aluop = 4'b0010; signop = 3'b001; end
        default: ;
      endcase
    end
  end

  // sequencing strobes and next state; a wait that hits the last count aborts to FETCH
  always_comb begin
    state_nx = state;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pcsrc    = 1'b0;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    waiting  = 1'b0;
    retire   = 1'b0;
    set_ill  = 1'b0;
    set_to   = 1'b0;
    case (state)
      S_FETCH: begin
        if (fetch_rdy) begin
          ir_write = 1'b1;
          state_nx = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          set_to   = 1'b1;
          pc_write = 1'b1;
        end else begin
          waiting  = 1'b1;
        end
      end
      S_DECODE: begin
        if (cls == CL_ILL) begin
          set_ill  = 1'b1;
          pc_write = 1'b1;
          state_nx = S_FETCH;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls == CL_B || cls == CL_CBZ) begin
          pc_write = 1'b1;
          pcsrc    = (cls == CL_B) ? 1'b1 : zero;
          retire   = 1'b1;
          state_nx = S_FETCH;
        end else if (cls == CL_LDUR || cls == CL_STUR) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          memread  = (cls == CL_LDUR);
          memwrite = (cls != CL_LDUR);
          if (cls == CL_LDUR) begin
            state_nx = S_WB;
          end else begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_nx = S_FETCH;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          set_to   = 1'b1;
          pc_write = 1'b1;
          state_nx = S_FETCH;
        end else begin
          memread  = (cls == CL_LDUR);
          memwrite = (cls != CL_LDUR);
          waiting  = 1'b1;
        end
      end
      S_WB: begin
        regwrite = 1'b1;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_nx = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  // state, wait counter, sticky flags and retired-instruction counter
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
      retired  <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
      if (set_ill) illegal <= 1'b1;
      if (set_to)  timeout <= 1'b1;
      if (retire)  retired <= retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed and randomized instruction streams for multicycle_control,
// checked cycle by cycle against an instruction-level expected-trace model.
`timescale 1ns/1ps
module tb_multicycle_control;
  localparam int MEM_TO = 16;
  localparam int CNT_W  = 4;

  localparam int C_ILL = 0, C_AND = 1, C_ORR = 2, C_ADD = 3, C_SUB = 4, C_ADDI = 5,
                 C_SUBI = 6, C_MOVZ = 7, C_B = 8, C_CBZ = 9, C_LDUR = 10, C_STUR = 11;

  // strobe vector order: {ir_write, pc_write, pcsrc, regwrite, memread, memwrite}
  localparam logic [5:0] S_IRW = 6'b100000, S_PCW = 6'b010000, S_PCS = 6'b001000,
                         S_RW  = 6'b000100, S_MR  = 6'b000010, S_MW  = 6'b000001;

  logic             CLK = 1'b0;
  logic             resetl;
  logic [10:0]      opcode;
  logic             zero, imem_ready, dmem_ready;
  logic             ir_write, pc_write, pcsrc, reg2loc, alusrc, mem2reg, regwrite, memread, memwrite;
  logic [3:0]       aluop;
  logic [2:0]       signop, state;
  logic             illegal, timeout;
  logic [CNT_W-1:0] retired;

  int n_checks = 0;
  int n_errors = 0;
  int exp_ret  = 0;
  bit exp_ill  = 1'b0;
  bit exp_to   = 1'b0;
  int instr_no = 0;

  typedef struct {
    logic [2:0] st;
    logic       imr, dmr, z;
    logic [5:0] strb;
    bit         ret, set_to, set_ill;
  } cyc_t;

  cyc_t q[$];

  string pats [12] = '{"?0001010???", "?0101010???", "?0?01011???", "?1?01011???",
                       "?0?10001???", "?1?10001???", "110100101??", "?00101?????",
                       "?011010????", "??111000010", "??111000000", "???????????"};

  multicycle_control #(.MEM_TO(MEM_TO), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .resetl(resetl), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pcsrc(pcsrc), .reg2loc(reg2loc),
    .alusrc(alusrc), .mem2reg(mem2reg), .regwrite(regwrite), .memread(memread),
    .memwrite(memwrite), .aluop(aluop), .signop(signop), .state(state),
    .illegal(illegal), .timeout(timeout), .retired(retired)
  );

  always #5 CLK = ~CLK;

  function automatic bit pmatch(logic [10:0] op, string pat);
    for (int i = 0; i < 11; i++) begin
      if (pat[i] == "0" && op[10-i] !== 1'b0) return 1'b0;
      if (pat[i] == "1" && op[10-i] !== 1'b1) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int classify(logic [10:0] op);
    if (pmatch(op, "?0001010???")) return C_AND;
    if (pmatch(op, "?0101010???")) return C_ORR;
    if (pmatch(op, "?0?01011???")) return C_ADD;
    if (pmatch(op, "?1?01011???")) return C_SUB;
    if (pmatch(op, "?0?10001???")) return C_ADDI;
    if (pmatch(op, "?1?10001???")) return C_SUBI;
`ifdef MOVZ_EN
    if (pmatch(op, "110100101??")) return C_MOVZ;
`endif
    if (pmatch(op, "?00101?????")) return C_B;
    if (pmatch(op, "?011010????")) return C_CBZ;
    if (pmatch(op, "??111000010")) return C_LDUR;
    if (pmatch(op, "??111000000")) return C_STUR;
    return C_ILL;
  endfunction

  // {reg2loc, alusrc, mem2reg, aluop[3:0], signop[2:0]} per instruction class
  function automatic logic [9:0] ctl_of(int cls);
    case (cls)
      C_AND:   return {3'b000, 4'b0000, 3'b000};
      C_ORR:   return {3'b000, 4'b0001, 3'b000};
      C_ADD:   return {3'b000, 4'b0010, 3'b000};
      C_SUB:   return {3'b000, 4'b0110, 3'b000};
      C_ADDI:  return {3'b010, 4'b0010, 3'b000};
      C_SUBI:  return {3'b010, 4'b0110, 3'b000};
      C_MOVZ:  return {3'b010, 4'b0111, 3'b100};
      C_B:     return {3'b000, 4'b0000, 3'b010};
      C_CBZ:   return {3'b100, 4'b0111, 3'b011};
      C_LDUR:  return {3'b011, 4'b0010, 3'b001};
      C_STUR:  return {3'b110, 4'b0010, 3'b001};
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic [10:0] fill(string pat);
    logic [10:0] r;
    for (int i = 0; i < 11; i++)
      r[10-i] = (pat[i] == "?") ? 1'($urandom) : (pat[i] == "1");
    return r;
  endfunction

  function automatic cyc_t mk(logic [2:0] st, logic imr, logic dmr);
    cyc_t c;
    c.st = st; c.imr = imr; c.dmr = dmr; c.z = 1'($urandom);
    c.strb = 6'b0; c.ret = 1'b0; c.set_to = 1'b0; c.set_ill = 1'b0;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected per-cycle trace of one instruction: iw/dw are memory wait cycles before ready,
  // a wait of MEM_TO or more means ready never arrives and the instruction times out
  task automatic build(input logic [10:0] op, input int iw, input int dw, input int ez);
    int cls = classify(op);
    cyc_t c;
    logic [5:0] s;
    if (iw >= MEM_TO) begin
      for (int k = 0; k < MEM_TO - 1; k++) q.push_back(mk(3'd0, 1'b0, 1'($urandom)));
      c = mk(3'd0, 1'b0, 1'($urandom)); c.strb = S_PCW; c.set_to = 1'b1; q.push_back(c);
      return;
    end
    for (int k = 0; k < iw; k++) q.push_back(mk(3'd0, 1'b0, 1'($urandom)));
    c = mk(3'd0, 1'b1, 1'($urandom)); c.strb = S_IRW; q.push_back(c);
    c = mk(3'd1, 1'($urandom), 1'($urandom));
    if (cls == C_ILL) begin
      c.strb = S_PCW; c.set_ill = 1'b1; q.push_back(c);
      return;
    end
    q.push_back(c);
    c = mk(3'd2, 1'($urandom), 1'($urandom));
    if (ez >= 0) c.z = ez[0];
    if (cls == C_B || cls == C_CBZ) begin
      c.strb = S_PCW | ((cls == C_B || c.z) ? S_PCS : 6'b0); c.ret = 1'b1; q.push_back(c);
      return;
    end
    q.push_back(c);
    if (cls == C_LDUR || cls == C_STUR) begin
      s = (cls == C_LDUR) ? S_MR : S_MW;
      if (dw >= MEM_TO) begin
        for (int k = 0; k < MEM_TO - 1; k++) begin
          c = mk(3'd3, 1'($urandom), 1'b0); c.strb = s; q.push_back(c);
        end
        c = mk(3'd3, 1'($urandom), 1'b0); c.strb = S_PCW; c.set_to = 1'b1; q.push_back(c);
        return;
      end
      for (int k = 0; k < dw; k++) begin
        c = mk(3'd3, 1'($urandom), 1'b0); c.strb = s; q.push_back(c);
      end
      c = mk(3'd3, 1'($urandom), 1'b1); c.strb = s;
      if (cls == C_STUR) begin
        c.strb = c.strb | S_PCW; c.ret = 1'b1; q.push_back(c);
        return;
      end
      q.push_back(c);
    end
    c = mk(3'd4, 1'($urandom), 1'($urandom)); c.strb = S_RW | S_PCW; c.ret = 1'b1; q.push_back(c);
  endtask

  task automatic replay(input logic [10:0] op, input int limit);
    int cls = classify(op);
    int n = 0;
    cyc_t c;
    while (q.size() > 0 && n < limit) begin
      c = q.pop_front();
      opcode = op; imem_ready = c.imr; dmem_ready = c.dmr; zero = c.z;
      #1;
      chk($sformatf("i%0d_c%0d_state", instr_no, n), 32'(state), 32'(c.st));
      chk($sformatf("i%0d_c%0d_strobes", instr_no, n),
          32'({ir_write, pc_write, pcsrc, regwrite, memread, memwrite}), 32'(c.strb));
      chk($sformatf("i%0d_c%0d_ctl", instr_no, n),
          32'({reg2loc, alusrc, mem2reg, aluop, signop}), 32'((c.st == 3'd0) ? 10'b0 : ctl_of(cls)));
      chk($sformatf("i%0d_c%0d_flags", instr_no, n), 32'({illegal, timeout}), 32'({exp_ill, exp_to}));
      chk($sformatf("i%0d_c%0d_retired", instr_no, n), 32'(retired), 32'(exp_ret));
      if (c.ret) exp_ret = (exp_ret + 1) % (1 << CNT_W);
      if (c.set_to) exp_to = 1'b1;
      if (c.set_ill) exp_ill = 1'b1;
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic run(input logic [10:0] op, input int iw, input int dw, input int ez);
    q.delete();
    build(op, iw, dw, ez);
    replay(op, 1000);
    instr_no++;
  endtask

  function automatic int pick_wait();
    int r = $urandom_range(0, 19);
    if (r < 14) return r % 4;
    if (r < 17) return MEM_TO - 1;
    return MEM_TO;
  endfunction

  initial begin
    logic [10:0] op;
    int k;

    resetl = 1'b0; opcode = 11'h458; zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    #3;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_strobes", 32'({ir_write, pc_write, pcsrc, regwrite, memread, memwrite}), 32'd0);
    chk("reset_ctl", 32'({reg2loc, alusrc, mem2reg, aluop, signop}), 32'd0);
    chk("reset_flags", 32'({illegal, timeout}), 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    @(negedge CLK);
    resetl = 1'b1;

    run(11'h458, 0, 0, -1);           // ADDREG, no wait
    run(11'h7C2, 1, 2, -1);           // LDUR, memread for 3 cycles
    run(11'h5A0, 0, 0, 1);            // CBZ taken
    run(11'h5A0, 2, 0, 0);            // CBZ not taken
    run(11'h7C0, 0, MEM_TO + 4, -1);  // STUR data-memory timeout
    run(11'h000, 0, 0, -1);           // illegal opcode skipped
    run(11'h694, 1, 0, -1);           // MOVZ, legal only with MOVZ_EN
    run(11'h7C2, MEM_TO, 0, -1);      // instruction-fetch timeout
    run(11'h458, MEM_TO - 1, 0, -1);  // ready on the last allowed fetch cycle
    run(11'h7C0, 0, MEM_TO - 1, -1);  // ready on the last allowed MEM cycle

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 11);
      op = fill(pats[k]);
      run(op, pick_wait(), pick_wait(), -1);
    end

    // asynchronous reset in the middle of a load's MEM wait
    q.delete();
    build(11'h7C2, 0, MEM_TO + 4, -1);
    replay(11'h7C2, 5);
    imem_ready = 1'b1; dmem_ready = 1'b0;
    #1;
    chk("midmem_memread", 32'(memread), 32'd1);
    #2;
    resetl = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_strobes", 32'({ir_write, pc_write, pcsrc, regwrite, memread, memwrite}), 32'd0);
    chk("async_rst_ctl", 32'({reg2loc, alusrc, mem2reg, aluop, signop}), 32'd0);
    chk("async_rst_flags", 32'({illegal, timeout}), 32'd0);
    chk("async_rst_retired", 32'(retired), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
